// File: rtl/eth_rx_commit_writer.sv
// eth_rx_commit_writer: receive-path bus write back end.
// Holds payload until a good verdict (COMMIT_MODE=1) or writes it straight through.
module eth_rx_commit_writer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int SEL_W       = 6,
    parameter int DEPTH_LOG2  = 6,
    parameter int COMMIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_start,
    input  logic [1:0]        sel_type_i,
    input  logic [SEL_W-1:0]  sel_index_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word_data,
    input  logic              pkt_ok_i,
    input  logic              pkt_err_i,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              sel_ram,
    output logic              sel_fifo,
    output logic              sel_register,
    output logic [SEL_W-1:0]  sel_index,
    output logic              wr_stb,
    output logic              busy,
    output logic              done_ok,
    output logic              done_err,
    output logic              fatal_ovr,
    output logic [7:0]        drop_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = (ADDR_W > DEPTH_LOG2) ? ADDR_W : DEPTH_LOG2 + 1;
    localparam logic [1:0] T_RAM  = 2'd0;
    localparam logic [1:0] T_FIFO = 2'd1;
    localparam logic [1:0] T_REG  = 2'd2;
    localparam logic [1:0] T_NONE = 2'd3;
    localparam bit BUFFERED = (COMMIT_MODE != 0);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        type_q, type_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]     n_q, n_d, k_q, k_d;
    logic              ovf_q, ovf_d, ign_q, ign_d;
    logic              ok_q, ok_d, err_q, err_d;
    logic              fatal_q, fatal_d;
    logic [7:0]        drop_q, drop_d;
    logic              w_stb_q, w_stb_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [1:0]        w_type_q, w_type_d;
    logic [SEL_W-1:0]  w_idx_q, w_idx_d;
    logic              buf_we, drop_inc, verdict, word_take;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [ADDR_W-1:0] wr_addr(input logic [1:0] t,
                                                  input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] off);
        return (t == T_FIFO) ? off : b + off;
    endfunction

    assign verdict   = pkt_ok_i | pkt_err_i;
    assign word_take = word_valid && (type_q != T_NONE);

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        idx_d    = idx_q;
        base_d   = base_q;
        n_d      = n_q;
        k_d      = k_q;
        ovf_d    = ovf_q;
        ign_d    = ign_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        fatal_d  = fatal_q;
        drop_d   = drop_q;
        w_stb_d  = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        w_type_d = w_type_q;
        w_idx_d  = w_idx_q;
        buf_we   = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pkt_start) begin
                    state_d = S_COLLECT;
                    type_d  = sel_type_i;
                    idx_d   = sel_index_i;
                    base_d  = base_addr_i;
                    n_d     = '0;
                    ovf_d   = 1'b0;
                    ign_d   = 1'b0;
                end else if (ign_q && verdict) begin
                    ign_d    = 1'b0;
                    err_d    = 1'b1;
                    drop_inc = 1'b1;
                end
            end
            S_COLLECT: begin
                if (pkt_start) begin
                    // Abandon the open packet and restart on the new header.
                    err_d    = 1'b1;
                    drop_inc = 1'b1;
                    type_d   = sel_type_i;
                    idx_d    = sel_index_i;
                    base_d   = base_addr_i;
                    n_d      = '0;
                    ovf_d    = 1'b0;
                end else begin
                    if (word_take) begin
                        if (BUFFERED) begin
                            if (n_q == CW'(DEPTH)) begin
                                ovf_d   = 1'b1;
                                fatal_d = 1'b1;
                            end else begin
                                buf_we = 1'b1;
                                n_d    = n_q + CW'(1);
                            end
                        end else begin
                            w_stb_d  = 1'b1;
                            w_addr_d = wr_addr(type_q, base_q, ADDR_W'(n_q));
                            w_data_d = word_data;
                            w_type_d = type_q;
                            w_idx_d  = idx_q;
                            n_d      = n_q + CW'(1);
                        end
                    end
                    if (pkt_err_i) begin
                        state_d  = S_IDLE;
                        err_d    = 1'b1;
                        drop_inc = 1'b1;
                    end else if (pkt_ok_i) begin
                        state_d = S_IDLE;
                        if (!BUFFERED) begin
                            ok_d = 1'b1;
                        end else if (ovf_d) begin
                            err_d    = 1'b1;
                            drop_inc = 1'b1;
                        end else if (n_d == '0 || type_q == T_NONE) begin
                            ok_d = 1'b1;
                        end else begin
                            state_d = S_COMMIT;
                            k_d     = '0;
                        end
                    end
                end
            end
            S_COMMIT: begin
                // A header arriving now cannot be buffered; its packet is dropped.
                if (pkt_start) begin
                    fatal_d = 1'b1;
                    ign_d   = 1'b1;
                end else if (ign_q && verdict) begin
                    ign_d    = 1'b0;
                    err_d    = 1'b1;
                    drop_inc = 1'b1;
                end
                if (k_q == n_q - CW'(1)) begin
                    state_d = S_IDLE;
                    ok_d    = 1'b1;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (buf_we) mem[n_q[DEPTH_LOG2-1:0]] <= word_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            type_q   <= '0;
            idx_q    <= '0;
            base_q   <= '0;
            n_q      <= '0;
            k_q      <= '0;
            ovf_q    <= 1'b0;
            ign_q    <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            fatal_q  <= 1'b0;
            drop_q   <= '0;
            w_stb_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_type_q <= '0;
            w_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            n_q      <= n_d;
            k_q      <= k_d;
            ovf_q    <= ovf_d;
            ign_q    <= ign_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            fatal_q  <= fatal_d;
            drop_q   <= drop_d;
            w_stb_q  <= w_stb_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            w_type_q <= w_type_d;
            w_idx_q  <= w_idx_d;
        end
    end

    logic              stb;
    logic [1:0]        ty;
    logic [SEL_W-1:0]  ix;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] dt;

    always_comb begin
        if (BUFFERED) begin
            stb = (state_q == S_COMMIT);
            ty  = type_q;
            ix  = idx_q;
            ad  = wr_addr(type_q, base_q, ADDR_W'(k_q));
            dt  = mem[k_q[DEPTH_LOG2-1:0]];
        end else begin
            stb = w_stb_q;
            ty  = w_type_q;
            ix  = w_idx_q;
            ad  = w_addr_q;
            dt  = w_data_q;
        end
    end

    assign wr_stb       = stb;
    assign bus_addr     = stb ? ad : '0;
    assign bus_data     = stb ? dt : '0;
    assign sel_ram      = stb && (ty == T_RAM);
    assign sel_fifo     = stb && (ty == T_FIFO);
    assign sel_register = stb && (ty == T_REG);
    assign sel_index    = stb ? ix : '0;
    assign busy         = (state_q != S_IDLE);
    assign done_ok      = ok_q;
    assign done_err     = err_q;
    assign fatal_ovr    = fatal_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_eth_rx_commit_writer.sv
// tb_eth_rx_commit_writer: directed and randomized checks of the commit writer
// in a buffered (4-word) configuration and a write-through configuration.
module tb_eth_rx_commit_writer;
    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] a;
        logic [31:0] d;
        logic [2:0]  s;
        logic [5:0]  i;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_start = 1'b0;
    logic [1:0]  sel_type_i = '0;
    logic [5:0]  sel_index_i = '0;
    logic [15:0] base_addr_i = '0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        pkt_ok_i = 1'b0;
    logic        pkt_err_i = 1'b0;

    logic [15:0] o_addr [2];
    logic [31:0] o_data [2];
    logic        o_ram [2], o_fifo [2], o_reg [2];
    logic [5:0]  o_idx [2];
    logic        o_stb [2], o_busy [2], o_ok [2], o_err [2], o_fatal [2];
    logic [7:0]  o_drop [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    wr_t wq [2][$];
    int  okq [2][$];
    int  erq [2][$];

    eth_rx_commit_writer #(.DEPTH_LOG2(2), .COMMIT_MODE(1)) u_buf (
        .clk(clk), .rst(rst), .pkt_start(pkt_start),
        .sel_type_i(sel_type_i), .sel_index_i(sel_index_i),
        .base_addr_i(base_addr_i), .word_valid(word_valid),
        .word_data(word_data), .pkt_ok_i(pkt_ok_i), .pkt_err_i(pkt_err_i),
        .bus_addr(o_addr[0]), .bus_data(o_data[0]), .sel_ram(o_ram[0]),
        .sel_fifo(o_fifo[0]), .sel_register(o_reg[0]),
        .sel_index(o_idx[0]), .wr_stb(o_stb[0]), .busy(o_busy[0]),
        .done_ok(o_ok[0]), .done_err(o_err[0]), .fatal_ovr(o_fatal[0]),
        .drop_cnt(o_drop[0])
    );

    eth_rx_commit_writer #(.COMMIT_MODE(0)) u_wt (
        .clk(clk), .rst(rst), .pkt_start(pkt_start),
        .sel_type_i(sel_type_i), .sel_index_i(sel_index_i),
        .base_addr_i(base_addr_i), .word_valid(word_valid),
        .word_data(word_data), .pkt_ok_i(pkt_ok_i), .pkt_err_i(pkt_err_i),
        .bus_addr(o_addr[1]), .bus_data(o_data[1]), .sel_ram(o_ram[1]),
        .sel_fifo(o_fifo[1]), .sel_register(o_reg[1]),
        .sel_index(o_idx[1]), .wr_stb(o_stb[1]), .busy(o_busy[1]),
        .done_ok(o_ok[1]), .done_err(o_err[1]), .fatal_ovr(o_fatal[1]),
        .drop_cnt(o_drop[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (o_stb[i])
                    wq[i].push_back(wr_t'{32'(cyc), o_addr[i], o_data[i],
                                    {o_ram[i], o_fifo[i], o_reg[i]}, o_idx[i]});
                if (o_ok[i]) okq[i].push_back(cyc);
                if (o_err[i]) erq[i].push_back(cyc);
            end
        end
    end

    function automatic logic [69:0] outs(input int i);
        return {o_addr[i], o_data[i], o_ram[i], o_fifo[i], o_reg[i], o_idx[i],
                o_stb[i], o_busy[i], o_ok[i], o_err[i], o_fatal[i], o_drop[i]};
    endfunction

    function automatic logic [15:0] exp_addr(input logic [1:0] t,
                                             input logic [15:0] b, input int k);
        return (t == 2'd1) ? 16'(k) : 16'(b + 16'(k));
    endfunction

    task automatic clear_mon;
        for (int i = 0; i < 2; i++) begin
            wq[i].delete();
            okq[i].delete();
            erq[i].delete();
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] t, input logic [5:0] ix,
                         input logic [15:0] b, input logic wv, input logic [31:0] wd,
                         input logic ok, input logic er, output int c);
        pkt_start = st;
        sel_type_i = t;
        sel_index_i = ix;
        base_addr_i = b;
        word_valid = wv;
        word_data = wd;
        pkt_ok_i = ok;
        pkt_err_i = er;
        c = cyc;
        @(posedge clk);
        #1;
        pkt_start = 1'b0;
        word_valid = 1'b0;
        pkt_ok_i = 1'b0;
        pkt_err_i = 1'b0;
    endtask

    task automatic idle(input int n);
        int c;
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, c);
    endtask

    task automatic start(input logic [1:0] t, input logic [5:0] ix, input logic [15:0] b);
        int c;
        drive(1, t, ix, b, 0, 0, 0, 0, c);
    endtask

    task automatic word(input logic [31:0] d, output int c);
        drive(0, 0, 0, 0, 1, d, 0, 0, c);
    endtask

    task automatic verdict(input logic ok, input logic er, output int c);
        drive(0, 0, 0, 0, 0, 0, ok, er, c);
    endtask

    task automatic word_verdict(input logic [31:0] d, input logic ok,
                                input logic er, output int c);
        drive(0, 0, 0, 0, 1, d, ok, er, c);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (outs(i) !== '0) begin
                bad++;
                $display("FAIL reset_hold inst%0d got %h want 0", i, outs(i));
            end
        end
        rst = 1'b0;
        clear_mon();
        idle(2);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (outs(i) !== '0) begin
                bad++;
                $display("FAIL reset_idle inst%0d got %h want 0", i, outs(i));
            end
        end
    endtask

    task automatic test_ram_commit;
        int c, vc;
        wr_t e [2];
        do_reset();
        start(2'd0, 6'd2, 16'd10);
        word(32'h5A5A, c);
        word(32'h55AA, c);
        verdict(1, 0, vc);
        total++;
        if (o_busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL ram_busy got %b want 1", o_busy[0]);
        end
        idle(4);
        e[0] = wr_t'{32'(vc + 1), 16'h000A, 32'h5A5A, 3'b100, 6'd2};
        e[1] = wr_t'{32'(vc + 2), 16'h000B, 32'h55AA, 3'b100, 6'd2};
        total++;
        if (wq[0].size() != 2) begin
            bad++;
            $display("FAIL ram_count got %0d want 2", wq[0].size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (wq[0][k] !== e[k]) begin
                    bad++;
                    $display("FAIL ram_wr%0d got %h want %h", k, wq[0][k], e[k]);
                end
            end
        end
        total++;
        if (okq[0].size() != 1 || okq[0][0] != vc + 3 || erq[0].size() != 0) begin
            bad++;
            $display("FAIL ram_done got ok=%0d err=%0d want ok at %0d",
                     okq[0].size(), erq[0].size(), vc + 3);
        end
    endtask

    task automatic test_fifo_err;
        int c, vc;
        do_reset();
        start(2'd1, 6'd0, 16'h0);
        word(32'h12345678, c);
        word(32'h87654321, c);
        verdict(0, 1, vc);
        idle(3);
        total++;
        if (wq[0].size() != 0) begin
            bad++;
            $display("FAIL fifo_err_writes got %0d want 0", wq[0].size());
        end
        total++;
        if (erq[0].size() != 1 || erq[0][0] != vc + 1 || okq[0].size() != 0) begin
            bad++;
            $display("FAIL fifo_err_done got err=%0d ok=%0d want err at %0d",
                     erq[0].size(), okq[0].size(), vc + 1);
        end
        total++;
        if (o_drop[0] !== 8'd1) begin
            bad++;
            $display("FAIL fifo_err_drop got %0d want 1", o_drop[0]);
        end
    endtask

    task automatic test_overflow;
        int c, vc;
        do_reset();
        start(2'd0, 6'd1, 16'h20);
        for (int k = 0; k < 5; k++) word(32'(100 + k), c);
        verdict(1, 0, vc);
        idle(3);
        total++;
        if (wq[0].size() != 0) begin
            bad++;
            $display("FAIL ovf_writes got %0d want 0", wq[0].size());
        end
        total++;
        if (erq[0].size() != 1 || erq[0][0] != vc + 1) begin
            bad++;
            $display("FAIL ovf_done got err=%0d want err at %0d", erq[0].size(), vc + 1);
        end
        total++;
        if (o_fatal[0] !== 1'b1 || o_drop[0] !== 8'd1) begin
            bad++;
            $display("FAIL ovf_flags got fatal=%b drop=%0d want 1 1", o_fatal[0], o_drop[0]);
        end
        idle(10);
        clear_mon();
        start(2'd0, 6'd1, 16'h20);
        word(32'hCAFE, c);
        verdict(1, 0, vc);
        idle(3);
        total++;
        if (wq[0].size() != 1 || o_fatal[0] !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got writes=%0d fatal=%b want 1 1",
                     wq[0].size(), o_fatal[0]);
        end
        do_reset();
        total++;
        if (o_fatal[0] !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got %b want 0", o_fatal[0]);
        end
    endtask

    task automatic test_addr_wrap;
        int c, vc;
        wr_t e [2];
        do_reset();
        start(2'd0, 6'd7, 16'hFFFF);
        word(32'h1111, c);
        word(32'h2222, c);
        verdict(1, 0, vc);
        idle(4);
        e[0] = wr_t'{32'(vc + 1), 16'hFFFF, 32'h1111, 3'b100, 6'd7};
        e[1] = wr_t'{32'(vc + 2), 16'h0000, 32'h2222, 3'b100, 6'd7};
        total++;
        if (wq[0].size() != 2) begin
            bad++;
            $display("FAIL wrap_count got %0d want 2", wq[0].size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (wq[0][k] !== e[k]) begin
                    bad++;
                    $display("FAIL wrap_wr%0d got %h want %h", k, wq[0][k], e[k]);
                end
            end
        end
    endtask

    task automatic test_start_in_commit;
        int c, vc;
        wr_t e;
        do_reset();
        start(2'd0, 6'd3, 16'h40);
        for (int k = 0; k < 4; k++) word(32'hA0 + 32'(k), c);
        verdict(1, 0, vc);
        start(2'd1, 6'd5, 16'h300);
        word(32'hDEAD, c);
        word(32'hBEEF, c);
        idle(3);
        verdict(1, 0, c);
        idle(3);
        total++;
        if (wq[0].size() != 4) begin
            bad++;
            $display("FAIL commit_start_count got %0d want 4", wq[0].size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                e = wr_t'{32'(vc + 1 + k), 16'h40 + 16'(k), 32'hA0 + 32'(k), 3'b100, 6'd3};
                total++;
                if (wq[0][k] !== e) begin
                    bad++;
                    $display("FAIL commit_start_wr%0d got %h want %h", k, wq[0][k], e);
                end
            end
        end
        total++;
        if (okq[0].size() != 1 || okq[0][0] != vc + 5) begin
            bad++;
            $display("FAIL commit_start_done got %0d want ok at %0d", okq[0].size(), vc + 5);
        end
        total++;
        if (o_fatal[0] !== 1'b1 || o_drop[0] !== 8'd1) begin
            bad++;
            $display("FAIL commit_start_flags got fatal=%b drop=%0d want 1 1",
                     o_fatal[0], o_drop[0]);
        end
    endtask

    task automatic test_mode0;
        int wc, vc;
        wr_t e;
        do_reset();
        start(2'd0, 6'd1, 16'h0);
        word(32'h5555, wc);
        verdict(0, 1, vc);
        idle(2);
        e = wr_t'{32'(wc + 1), 16'h0000, 32'h5555, 3'b100, 6'd1};
        total++;
        if (wq[1].size() != 1 || wq[1][0] !== e) begin
            bad++;
            $display("FAIL wt_write got n=%0d first=%h want %h", wq[1].size(),
                     (wq[1].size() > 0) ? wq[1][0] : '0, e);
        end
        total++;
        if (erq[1].size() != 1 || erq[1][0] != vc + 1 || o_drop[1] !== 8'd1) begin
            bad++;
            $display("FAIL wt_err got err=%0d drop=%0d want err at %0d drop 1",
                     erq[1].size(), o_drop[1], vc + 1);
        end
        start(2'd0, 6'd4, 16'h20);
        word(32'h7777, wc);
        total++;
        if (o_stb[1] !== 1'b1 || o_busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL wt_inflight got stb=%b busy=%b want 1 1", o_stb[1], o_busy[1]);
        end
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (outs(i) !== '0) begin
                bad++;
                $display("FAIL async_rst inst%0d got %h want 0", i, outs(i));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_random;
        wr_t ew [2][$];
        int eok [2];
        int eer [2];
        int drop_m [2];
        logic fat_m;
        int wc [$];
        logic [31:0] wd [$];
        logic [1:0] t;
        logic [5:0] ix;
        logic [15:0] b;
        logic ok, er, merge, good, ovf;
        logic [31:0] d;
        int n, v, c, vc;
        logic obad, ebad;
        do_reset();
        drop_m[0] = 0;
        drop_m[1] = 0;
        fat_m = 1'b0;
        for (int p = 0; p < 40; p++) begin
            t = 2'($urandom_range(0, 3));
            ix = 6'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            n = (t == 2'd3) ? $urandom_range(0, 4) : $urandom_range(0, 6);
            v = $urandom_range(0, 3);
            ok = (v != 2);
            er = (v >= 2);
            merge = (n > 0) && ($urandom_range(0, 1) == 1);
            wc.delete();
            wd.delete();
            vc = 0;
            clear_mon();
            start(t, ix, b);
            for (int k = 0; k < n; k++) begin
                idle($urandom_range(0, 1));
                d = $urandom;
                wd.push_back(d);
                if (merge && k == n - 1) begin
                    word_verdict(d, ok, er, c);
                    vc = c;
                end else begin
                    word(d, c);
                end
                wc.push_back(c);
            end
            if (!merge) begin
                idle($urandom_range(0, 1));
                verdict(ok, er, vc);
            end
            idle(n + 3);

            ew[0].delete();
            ew[1].delete();
            good = ok && !er;
            ovf = (t != 2'd3) && (n > 4);
            if (ovf) fat_m = 1'b1;
            eok[0] = -1;
            eer[0] = -1;
            if (!good || ovf) begin
                eer[0] = vc + 1;
                if (drop_m[0] < 255) drop_m[0]++;
            end else if (t == 2'd3 || n == 0) begin
                eok[0] = vc + 1;
            end else begin
                for (int k = 0; k < n; k++)
                    ew[0].push_back(wr_t'{32'(vc + 1 + k), exp_addr(t, b, k), wd[k],
                                          3'b100 >> t, ix});
                eok[0] = vc + n + 1;
            end
            eok[1] = -1;
            eer[1] = -1;
            if (t != 2'd3)
                for (int k = 0; k < n; k++)
                    ew[1].push_back(wr_t'{32'(wc[k] + 1), exp_addr(t, b, k), wd[k],
                                          3'b100 >> t, ix});
            if (good) begin
                eok[1] = vc + 1;
            end else begin
                eer[1] = vc + 1;
                if (drop_m[1] < 255) drop_m[1]++;
            end

            for (int i = 0; i < 2; i++) begin
                total++;
                if (wq[i].size() != ew[i].size()) begin
                    bad++;
                    $display("FAIL rnd%0d_inst%0d_count got %0d want %0d",
                             p, i, wq[i].size(), ew[i].size());
                end else begin
                    for (int k = 0; k < ew[i].size(); k++) begin
                        total++;
                        if (wq[i][k] !== ew[i][k]) begin
                            bad++;
                            $display("FAIL rnd%0d_inst%0d_wr%0d got %h want %h",
                                     p, i, k, wq[i][k], ew[i][k]);
                        end
                    end
                end
                obad = (eok[i] < 0) ? (okq[i].size() != 0)
                                    : (okq[i].size() != 1 || okq[i][0] != eok[i]);
                ebad = (eer[i] < 0) ? (erq[i].size() != 0)
                                    : (erq[i].size() != 1 || erq[i][0] != eer[i]);
                total++;
                if (obad || ebad) begin
                    bad++;
                    $display("FAIL rnd%0d_inst%0d_done got ok=%0d err=%0d want ok@%0d err@%0d",
                             p, i, okq[i].size(), erq[i].size(), eok[i], eer[i]);
                end
                total++;
                if (o_drop[i] !== 8'(drop_m[i])) begin
                    bad++;
                    $display("FAIL rnd%0d_inst%0d_drop got %0d want %0d",
                             p, i, o_drop[i], drop_m[i]);
                end
            end
            total++;
            if (o_fatal[0] !== fat_m) begin
                bad++;
                $display("FAIL rnd%0d_fatal got %b want %b", p, o_fatal[0], fat_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_commit();
        test_fifo_err();
        test_overflow();
        test_addr_wrap();
        test_start_in_commit();
        test_mode0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
